sha256_dhash_sequencer: RTL and testbench

Command-side initiator for sha256_core: takes an 80-byte block header and drives the core's init/next/mode/block interface to compute SHA-256(SHA-256(header)). It pads both passes, sequences three core operations, and captures the final digest. It sits between the miner work logic and sha256_core, replacing hand-driven testbench stimulus.

---
 rtl/sha256_dhash_sequencer_if.sv | 31 +++
 rtl/sha256_dhash_sequencer.sv | 169 ++++++++++++++++
 tb/tb_sha256_dhash_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_dhash_sequencer_if.sv
// Command/response bundle between the double-hash sequencer and sha256_core.
// master = sequencer side, slave = core side.
interface sha256_dhash_sequencer_if;
   logic         core_init;
   logic         core_next;
   logic         core_mode;
   logic [511:0] core_block;
   logic         core_ready;
   logic [255:0] core_digest;
   logic         core_digest_valid;

   modport master (
      output core_init,
      output core_next,
      output core_mode,
      output core_block,
      input  core_ready,
      input  core_digest,
      input  core_digest_valid
   );

   modport slave (
      input  core_init,
      input  core_next,
      input  core_mode,
      input  core_block,
      output core_ready,
      output core_digest,
      output core_digest_valid
   );
endinterface

// File: rtl/sha256_dhash_sequencer.sv
// Drives sha256_core through SHA-256(SHA-256(80-byte header)).
// Optional target compare: define SHA_SEQ_TARGET_CMP_EN.
module sha256_dhash_sequencer #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = 11
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [639:0] header,
   output logic         busy,
   output logic [255:0] hash,
   output logic         hash_valid,
   output logic         error,
`ifdef SHA_SEQ_TARGET_CMP_EN
   input  logic [255:0] target,
   output logic         hit,
`endif
   sha256_dhash_sequencer_if.master core
);

   typedef enum logic [2:0] {
      IDLE,
      B1_GO,
      B1_WAIT,
      B2_GO,
      B2_WAIT,
      H2_GO,
      H2_WAIT,
      DONE
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t          state;
   state_t          state_nxt;
   logic [127:0]    hdr_lo;
   logic [TO_W-1:0] to_cnt;
   logic [511:0]    blk_b1;
   logic [511:0]    blk_b2;
   logic [511:0]    blk_h2;
   logic [511:0]    blk_nxt;
   logic            in_go;
   logic            in_wait;
   logic            ready_seen;
   logic            expired;

   assign in_go   = (state == B1_GO) || (state == B2_GO) ||
                    (state == H2_GO);
   assign in_wait = (state == B1_WAIT) || (state == B2_WAIT) ||
                    (state == H2_WAIT);

   // The first wait cycle still sees the previous op's ready.
   assign ready_seen = in_wait && (to_cnt != '0) && core.core_ready;
   assign expired    = in_wait && !core.core_ready &&
                       (to_cnt == TO_LAST);

   assign blk_b1 = header[639:128];
   assign blk_b2 = {hdr_lo, 8'h80, 312'd0, 64'h0000_0000_0000_0280};
   // Second-pass block is loaded from the digest as it is captured.
   assign blk_h2 = {core.core_digest, 8'h80, 184'd0,
                    64'h0000_0000_0000_0100};

   always_comb begin
      state_nxt = state;
      blk_nxt   = core.core_block;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = B1_GO;
               blk_nxt   = blk_b1;
            end
         end
         B1_GO:   state_nxt = B1_WAIT;
         B1_WAIT: begin
            if (expired) begin
               state_nxt = IDLE;
            end else if (ready_seen) begin
               state_nxt = B2_GO;
               blk_nxt   = blk_b2;
            end
         end
         B2_GO:   state_nxt = B2_WAIT;
         B2_WAIT: begin
            if (expired) begin
               state_nxt = IDLE;
            end else if (ready_seen) begin
               state_nxt = H2_GO;
               blk_nxt   = blk_h2;
            end
         end
         H2_GO:   state_nxt = H2_WAIT;
         H2_WAIT: begin
            if (expired) begin
               state_nxt = IDLE;
            end else if (ready_seen) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         hdr_lo          <= '0;
         to_cnt          <= '0;
         busy            <= 1'b0;
         hash            <= '0;
         hash_valid      <= 1'b0;
         error           <= 1'b0;
         core.core_init  <= 1'b0;
         core.core_next  <= 1'b0;
         core.core_mode  <= 1'b1;
         core.core_block <= '0;
      end else begin
         state           <= state_nxt;
         core.core_block <= blk_nxt;
         core.core_mode  <= 1'b1;
         core.core_init  <= (state == B1_GO) || (state == H2_GO);
         core.core_next  <= (state == B2_GO);
         hash_valid      <= (state == DONE);
         error           <= expired;
         if (state == IDLE && start) begin
            hdr_lo <= header[127:0];
            busy   <= 1'b1;
         end
         if (state == DONE || expired) begin
            busy <= 1'b0;
         end
         if (state == H2_WAIT && ready_seen) begin
            hash <= core.core_digest;
         end
         if (in_go) begin
            to_cnt <= '0;
         end else if (in_wait) begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

`ifdef SHA_SEQ_TARGET_CMP_EN
   logic [255:0] hash_rev;

   // Digest bytes reversed give the little-endian work value.
   always_comb begin
      hash_rev = '0;
      for (int i = 0; i < 32; i++) begin
         hash_rev[8*i +: 8] = hash[255-8*i -: 8];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit <= 1'b0;
      end else begin
         hit <= (state == DONE) && (hash_rev <= target);
      end
   end
`endif

   a_init_next_excl : assert property (
      @(posedge clk) disable iff (!reset_n)
      !(core.core_init && core.core_next)
   );

endmodule

// File: tb/tb_sha256_dhash_sequencer.sv
// Bench for sha256_dhash_sequencer with a behavioural SHA-256 core stub.
// Table vectors plus hand sequences for ignore, timeout and reset.
module tb_sha256_dhash_sequencer;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic [639:0] header = '0;
   logic         busy;
   logic [255:0] hash;
   logic         hash_valid;
   logic         error;
`ifdef SHA_SEQ_TARGET_CMP_EN
   logic [255:0] target = '0;
   logic         hit;
`endif

   sha256_dhash_sequencer_if cif();

   always #5 clk = ~clk;

   sha256_dhash_sequencer #(
      .TIMEOUT_CYCLES(16),
      .TO_W(5)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .header(header),
      .busy(busy),
      .hash(hash),
      .hash_valid(hash_valid),
      .error(error),
`ifdef SHA_SEQ_TARGET_CMP_EN
      .target(target),
      .hit(hit),
`endif
      .core(cif)
   );

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] IV =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

   localparam logic [255:0] GEN_HASH =
      256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] hin,
                                             input logic [511:0] blk);
      logic [31:0] w [0:63];
      logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      {a, b, c, d, e, f, g, h} = hin;
      for (int t = 0; t < 64; t++) begin
         s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
         t1 = h + s1 + ((e & f) ^ (~e & g)) + K[t] + w[t];
         s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
         t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1;
         d = c; c = b; b = a; a = t1 + t2;
      end
      return {hin[255:224] + a, hin[223:192] + b,
              hin[191:160] + c, hin[159:128] + d,
              hin[127:96] + e, hin[95:64] + f,
              hin[63:32] + g, hin[31:0] + h};
   endfunction

   function automatic logic [511:0] mk_b2(input logic [639:0] hd);
      return {hd[127:0], 8'h80, 312'h0, 64'h0000_0000_0000_0280};
   endfunction

   function automatic logic [511:0] mk_h2(input logic [639:0] hd);
      logic [255:0] d1;
      d1 = compress(compress(IV, hd[639:128]), mk_b2(hd));
      return {d1, 8'h80, 184'h0, 64'h0000_0000_0000_0100};
   endfunction

   function automatic logic [255:0] dhash(input logic [639:0] hd);
      return compress(IV, mk_h2(hd));
   endfunction

   // Core stub: ready drops after a command and returns stub_lat cycles later.
   int           stub_lat = 5;
   bit           hang_next = 1'b0;
   int           scnt;
   logic [255:0] sst;
   byte          cmd_q [$];
   logic [511:0] blk_q [$];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cif.core_ready        <= 1'b1;
         cif.core_digest       <= '0;
         cif.core_digest_valid <= 1'b0;
         scnt                  <= 0;
         sst                   <= '0;
      end else begin
         cif.core_digest_valid <= 1'b0;
         if (cif.core_init || cif.core_next) begin
            sst            <= compress(cif.core_init ? IV : sst, cif.core_block);
            cif.core_ready <= 1'b0;
            scnt           <= (hang_next && cif.core_next) ? 0 : stub_lat - 1;
            cmd_q.push_back(cif.core_init ? 8'h49 : 8'h4e);
            blk_q.push_back(cif.core_block);
         end else if (scnt == 1) begin
            cif.core_ready        <= 1'b1;
            cif.core_digest       <= sst;
            cif.core_digest_valid <= 1'b1;
            scnt                  <= 0;
         end else if (scnt > 1) begin
            scnt <= scnt - 1;
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [511:0] got,
                      input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   function automatic logic [511:0] blk_at(input int i);
      return (i < blk_q.size()) ? blk_q[i] : '0;
   endfunction

   function automatic logic [23:0] cmds3();
      logic [23:0] r;
      r = '0;
      for (int i = 0; i < 3; i++)
         r = {r[15:0], (i < cmd_q.size()) ? cmd_q[i] : 8'h00};
      return r;
   endfunction

   task automatic run(input logic [639:0] hd, input int lat,
                      output int cyc, output logic [255:0] got,
                      output logic busy_at, output logic hv_after,
                      output logic hit_at);
      stub_lat = lat;
      cmd_q.delete();
      blk_q.delete();
      @(negedge clk);
      header = hd;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc   = 1;
      while (!hash_valid && !error && cyc < 400) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      got     = hash;
      busy_at = busy;
`ifdef SHA_SEQ_TARGET_CMP_EN
      hit_at = hit;
`else
      hit_at = 1'b0;
`endif
      @(posedge clk);
      #1;
      hv_after = hash_valid;
   endtask

   typedef struct {
      logic [639:0] hdr;
      int           lat;
      int           exp_cyc;
      logic [255:0] exp_hash;
      bit           known;
   } vec_t;

   vec_t         vt [0:3];
   logic [639:0] gen_hdr;
   logic [639:0] pat_hdr;
   logic [255:0] got, prev, hash_e;
   logic         busy_at, hv_after, hit_at, busy_e, err_after;
   int           cyc, nc, ec, ni, nvalid;
   bit           hv_seen, found;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      gen_hdr = {32'h01000000, 256'h0,
                 256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
                 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
      for (int i = 0; i < 80; i++) pat_hdr[639-8*i -: 8] = 8'(i * 7 + 3);

      vt[0] = '{hdr: gen_hdr, lat: 5, exp_cyc: 23, exp_hash: GEN_HASH, known: 1'b1};
      vt[1] = '{hdr: gen_hdr, lat: 2, exp_cyc: 14, exp_hash: GEN_HASH, known: 1'b1};
      vt[2] = '{hdr: '0, lat: 3, exp_cyc: 17, exp_hash: '0, known: 1'b0};
      vt[3] = '{hdr: pat_hdr, lat: 12, exp_cyc: 44, exp_hash: '0, known: 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 512'(busy), 512'(0));
      chk("rst_hash", 512'(hash), 512'(0));
      chk("rst_hash_valid", 512'(hash_valid), 512'(0));
      chk("rst_error", 512'(error), 512'(0));
      chk("rst_init", 512'(cif.core_init), 512'(0));
      chk("rst_next", 512'(cif.core_next), 512'(0));
      chk("rst_mode", 512'(cif.core_mode), 512'(1));
      chk("rst_block", cif.core_block, '0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int v = 0; v < 4; v++) begin
         run(vt[v].hdr, vt[v].lat, cyc, got, busy_at, hv_after, hit_at);
         chk($sformatf("v%0d_hash", v), 512'(got),
             512'(vt[v].known ? vt[v].exp_hash : dhash(vt[v].hdr)));
         chk($sformatf("v%0d_latency", v), 512'(cyc), 512'(vt[v].exp_cyc));
         chk($sformatf("v%0d_busy_done", v), 512'(busy_at), 512'(0));
         chk($sformatf("v%0d_single_valid", v), 512'(hv_after), 512'(0));
         chk($sformatf("v%0d_ncmds", v), 512'(cmd_q.size()), 512'(3));
         chk($sformatf("v%0d_cmd_order", v), 512'(cmds3()), 512'(24'h494e49));
         chk($sformatf("v%0d_blk_b1", v), blk_at(0), vt[v].hdr[639:128]);
         chk($sformatf("v%0d_blk_b2", v), blk_at(1), mk_b2(vt[v].hdr));
         chk($sformatf("v%0d_blk_h2", v), blk_at(2), mk_h2(vt[v].hdr));
      end

      // Second start while busy must be ignored
      stub_lat = 5;
      cmd_q.delete();
      blk_q.delete();
      @(negedge clk);
      header = pat_hdr;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      header = {80{8'hff}};
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      nvalid = 0;
      for (int i = 0; i < 40; i++) begin
         if (hash_valid) begin
            nvalid++;
            got = hash;
         end
         @(posedge clk);
         #1;
      end
      chk("ign_valid_count", 512'(nvalid), 512'(1));
      chk("ign_hash", 512'(got), 512'(dhash(pat_hdr)));
      chk("ign_ncmds", 512'(cmd_q.size()), 512'(3));
      chk("ign_busy_after", 512'(busy), 512'(0));

      // Core hangs after next: timeout error
      prev      = hash;
      hang_next = 1'b1;
      stub_lat  = 5;
      @(negedge clk);
      header = gen_hdr;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      cyc     = 1;
      nc      = -1;
      hv_seen = 1'b0;
      while (cyc < 200) begin
         if (cif.core_next && nc < 0) nc = cyc;
         if (hash_valid) hv_seen = 1'b1;
         if (error) break;
         @(posedge clk);
         #1;
         cyc++;
      end
      ec     = error ? cyc : -1000;
      busy_e = busy;
      hash_e = hash;
      @(posedge clk);
      #1;
      err_after = error;
      chk("to_next_cycle", 512'(nc), 512'(9));
      chk("to_error_delay", 512'(ec - nc), 512'(16));
      chk("to_busy", 512'(busy_e), 512'(0));
      chk("to_hash_kept", 512'(hash_e), 512'(prev));
      chk("to_no_valid", 512'(hv_seen), 512'(0));
      chk("to_error_pulse", 512'(err_after), 512'(0));
      hang_next = 1'b0;

      // Reset asserted in H2_WAIT while core_init is high
      stub_lat = 5;
      @(negedge clk);
      header = gen_hdr;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc   = 1;
      ni    = 0;
      found = 1'b0;
      while (cyc < 100) begin
         if (cif.core_init) begin
            ni++;
            if (ni == 2) begin
               found = 1'b1;
               break;
            end
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("rmid_found_h2", 512'(found), 512'(1));
      chk("rmid_h2_cycle", 512'(cyc), 512'(16));
      #2;
      reset_n = 1'b0;
      #1;
      chk("rmid_busy", 512'(busy), 512'(0));
      chk("rmid_hash", 512'(hash), 512'(0));
      chk("rmid_hash_valid", 512'(hash_valid), 512'(0));
      chk("rmid_init", 512'(cif.core_init), 512'(0));
      chk("rmid_next", 512'(cif.core_next), 512'(0));
      chk("rmid_mode", 512'(cif.core_mode), 512'(1));
      chk("rmid_block", cif.core_block, '0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      run(gen_hdr, 5, cyc, got, busy_at, hv_after, hit_at);
      chk("rpost_hash", 512'(got), 512'(GEN_HASH));
      chk("rpost_latency", 512'(cyc), 512'(23));

`ifdef SHA_SEQ_TARGET_CMP_EN
      target = {32'h0, 16'hffff, 208'h0};
      run(gen_hdr, 5, cyc, got, busy_at, hv_after, hit_at);
      chk("hit_easy_target", 512'(hit_at), 512'(1));
      chk("hit_after_valid", 512'(hit), 512'(0));
      target = '0;
      run(gen_hdr, 5, cyc, got, busy_at, hv_after, hit_at);
      chk("hit_zero_target", 512'(hit_at), 512'(0));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
